// File: rtl/load_store_unit.sv
// Load/store initiator: turns byte/half/word CPU accesses into aligned word
// accesses on a single-port memory with a registered read (read-modify-write for sub-word stores).
module load_store_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            is_store,
    input  logic [1:0]      size,
    input  logic            uns,
    input  logic [XLEN-1:0] addr,
    input  logic [XLEN-1:0] wdata,
    output logic            busy,
    output logic            done,
    output logic            err,
    output logic [XLEN-1:0] rdata,
    output logic [XLEN-1:0] mem_a,
    output logic [XLEN-1:0] mem_wd,
    output logic            mem_we,
    input  logic [XLEN-1:0] mem_rd
);

    typedef enum logic [2:0] {S_IDLE, S_RD, S_CAP, S_WR, S_DONE} state_t;

    state_t          r_state, w_next;
    logic            r_store, r_uns, r_err;
    logic [1:0]      r_size, r_off;
    logic [XLEN-1:0] r_wdata, r_rdata, r_mem_a, r_mem_wd;
    logic            w_misal;

    function automatic logic [XLEN-1:0] extend_load(input logic [XLEN-1:0] word,
                                                    input logic [1:0] sz,
                                                    input logic [1:0] off,
                                                    input logic u);
        logic [XLEN-1:0] sh;
        sh = word >> {off, 3'b000};
        case (sz)
            2'b00:   extend_load = u ? {{(XLEN-8){1'b0}}, sh[7:0]} : {{(XLEN-8){sh[7]}}, sh[7:0]};
            2'b01:   extend_load = u ? {{(XLEN-16){1'b0}}, sh[15:0]} : {{(XLEN-16){sh[15]}}, sh[15:0]};
            default: extend_load = word;
        endcase
    endfunction

    function automatic logic [XLEN-1:0] merge_store(input logic [XLEN-1:0] word,
                                                    input logic [XLEN-1:0] wd,
                                                    input logic [1:0] sz,
                                                    input logic [1:0] off);
        logic [XLEN-1:0] mask, lane;
        if (sz == 2'b00) begin
            mask = {{(XLEN-8){1'b0}}, 8'hFF} << {off, 3'b000};
            lane = {{(XLEN-8){1'b0}}, wd[7:0]} << {off, 3'b000};
        end else begin
            mask = {{(XLEN-16){1'b0}}, 16'hFFFF} << {off[1], 4'b0000};
            lane = {{(XLEN-16){1'b0}}, wd[15:0]} << {off[1], 4'b0000};
        end
        merge_store = (word & ~mask) | lane;
    endfunction

    assign w_misal = (size == 2'b11) ||
                     (size == 2'b01 && addr[0]) ||
                     (size == 2'b10 && addr[1:0] != 2'b00);

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    if (w_misal)                          w_next = S_DONE;
                    else if (is_store && size == 2'b10)   w_next = S_WR;
                    else                                  w_next = S_RD;
                end
            end
            S_RD:    w_next = S_CAP;
            S_CAP:   w_next = r_store ? S_WR : S_DONE;
            S_WR:    w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_store  <= 1'b0;
            r_uns    <= 1'b0;
            r_err    <= 1'b0;
            r_size   <= 2'b00;
            r_off    <= 2'b00;
            r_wdata  <= '0;
            r_rdata  <= '0;
            r_mem_a  <= '0;
            r_mem_wd <= '0;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_store  <= is_store;
                        r_uns    <= uns;
                        r_size   <= size;
                        r_off    <= addr[1:0];
                        r_wdata  <= wdata;
                        r_err    <= w_misal;
                        r_mem_a  <= {addr[XLEN-1:2], 2'b00};
                        // Word stores go straight to WR, so the full word is staged now
                        r_mem_wd <= wdata;
                    end
                end
                S_CAP: begin
                    if (r_store) r_mem_wd <= merge_store(mem_rd, r_wdata, r_size, r_off);
                    else         r_rdata  <= extend_load(mem_rd, r_size, r_off, r_uns);
                end
                default: ;
            endcase
        end
    end

    assign busy   = (r_state != S_IDLE);
    assign done   = (r_state == S_DONE);
    assign err    = done && r_err;
    assign rdata  = r_rdata;
    assign mem_a  = r_mem_a;
    assign mem_wd = r_mem_wd;
    // Reset kills an in-flight write in the same cycle it is asserted
    assign mem_we = (r_state == S_WR) && !rst;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a behavioural 1-cycle registered-read word memory.
module tb_load_store_unit;

    logic        clk = 1'b0, rst = 1'b1, start = 1'b0, is_store = 1'b0, uns = 1'b0;
    logic [1:0]  size = 2'b00;
    logic [31:0] addr = '0, wdata = '0;
    logic        busy, done, err, mem_we;
    logic [31:0] rdata, mem_a, mem_wd;
    logic [31:0] mem_rd = '0;
    logic [31:0] mem [0:255] = '{default: 32'h0};

    int n_checks = 0;
    int n_fail   = 0;

    int          op_done_cyc, op_we_cyc, op_we_cnt;
    logic [31:0] op_we_a, op_we_d, op_rdata, op_a1;
    logic        op_err;

    load_store_unit #(.XLEN(32)) dut (
        .clk(clk), .rst(rst), .start(start), .is_store(is_store), .size(size),
        .uns(uns), .addr(addr), .wdata(wdata), .busy(busy), .done(done), .err(err),
        .rdata(rdata), .mem_a(mem_a), .mem_wd(mem_wd), .mem_we(mem_we), .mem_rd(mem_rd)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_we) mem[mem_a[9:2]] <= mem_wd;
        else        mem_rd <= mem[mem_a[9:2]];
    end

    // Issue one request and record cycle-by-cycle observations (cycle k = T+k).
    task automatic run_op(input logic st, input logic [1:0] sz, input logic u,
                          input logic [31:0] a, input logic [31:0] wd, input int hold);
        @(negedge clk);
        is_store = st; size = sz; uns = u; addr = a; wdata = wd; start = 1'b1;
        op_done_cyc = -1; op_we_cyc = -1; op_we_cnt = 0;
        op_we_a = '0; op_we_d = '0; op_rdata = '0; op_a1 = '0; op_err = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk); #1;
            if (k >= hold) start = 1'b0;
            if (k == 1) begin
                op_a1 = mem_a;
                addr = ~a; wdata = ~wd; size = ~sz; uns = ~u; is_store = ~st;
            end
            if (mem_we === 1'b1) begin
                op_we_cnt++; op_we_cyc = k; op_we_a = mem_a; op_we_d = mem_wd;
            end
            if (done === 1'b1 && op_done_cyc < 0) begin
                op_done_cyc = k; op_err = err; op_rdata = rdata;
            end
            if (op_done_cyc > 0 && k == op_done_cyc + 1) break;
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (busy !== 1'b0)  begin n_fail++; $display("FAIL rst_busy got=%b exp=0", busy); end
        n_checks++; if (done !== 1'b0)  begin n_fail++; $display("FAIL rst_done got=%b exp=0", done); end
        n_checks++; if (err !== 1'b0)   begin n_fail++; $display("FAIL rst_err got=%b exp=0", err); end
        n_checks++; if (rdata !== 32'h0) begin n_fail++; $display("FAIL rst_rdata got=%h exp=0", rdata); end
        n_checks++; if (mem_a !== 32'h0) begin n_fail++; $display("FAIL rst_mem_a got=%h exp=0", mem_a); end
        n_checks++; if (mem_wd !== 32'h0) begin n_fail++; $display("FAIL rst_mem_wd got=%h exp=0", mem_wd); end
        n_checks++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL rst_mem_we got=%b exp=0", mem_we); end
        @(negedge clk); rst = 1'b0;
    endtask

    task automatic test_word_store();
        run_op(1'b1, 2'b10, 1'b0, 32'h100, 32'h8899AABB, 1);
        n_checks++; if (op_we_cyc !== 1) begin n_fail++; $display("FAIL ws_we_cyc got=%0d exp=1", op_we_cyc); end
        n_checks++; if (op_we_a !== 32'h100) begin n_fail++; $display("FAIL ws_mem_a got=%h exp=00000100", op_we_a); end
        n_checks++; if (op_we_d !== 32'h8899AABB) begin n_fail++; $display("FAIL ws_mem_wd got=%h exp=8899aabb", op_we_d); end
        n_checks++; if (op_we_cnt !== 1) begin n_fail++; $display("FAIL ws_we_cnt got=%0d exp=1", op_we_cnt); end
        n_checks++; if (op_done_cyc !== 2) begin n_fail++; $display("FAIL ws_done_cyc got=%0d exp=2", op_done_cyc); end
        n_checks++; if (op_err !== 1'b0) begin n_fail++; $display("FAIL ws_err got=%b exp=0", op_err); end
    endtask

    task automatic test_loads();
        logic        t_uns [5]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        logic [1:0]  t_sz  [5]  = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b10};
        logic [31:0] t_a   [5]  = '{32'h102, 32'h102, 32'h100, 32'h102, 32'h100};
        logic [31:0] t_exp [5]  = '{32'hFFFFFF99, 32'h00000099, 32'hFFFFAABB, 32'h00008899, 32'h8899AABB};
        for (int i = 0; i < 5; i++) begin
            run_op(1'b0, t_sz[i], t_uns[i], t_a[i], 32'h0, 1);
            n_checks++; if (op_rdata !== t_exp[i]) begin n_fail++; $display("FAIL ld%0d_rdata got=%h exp=%h", i, op_rdata, t_exp[i]); end
            n_checks++; if (op_done_cyc !== 3) begin n_fail++; $display("FAIL ld%0d_done_cyc got=%0d exp=3", i, op_done_cyc); end
            n_checks++; if (op_we_cnt !== 0) begin n_fail++; $display("FAIL ld%0d_we_cnt got=%0d exp=0", i, op_we_cnt); end
        end
    endtask

    task automatic test_subword_store();
        logic [1:0]  t_sz  [3] = '{2'b00, 2'b01, 2'b00};
        logic [31:0] t_a   [3] = '{32'h101, 32'h102, 32'h103};
        logic [31:0] t_wd  [3] = '{32'hFFFFFF5A, 32'hFFFF1234, 32'h000000C3};
        logic [31:0] t_exp [3] = '{32'h88995ABB, 32'h12345ABB, 32'hC3345ABB};
        for (int i = 0; i < 3; i++) begin
            run_op(1'b1, t_sz[i], 1'b0, t_a[i], t_wd[i], 1);
            n_checks++; if (op_a1 !== 32'h100) begin n_fail++; $display("FAIL st%0d_rd_mem_a got=%h exp=00000100", i, op_a1); end
            n_checks++; if (op_we_cyc !== 3) begin n_fail++; $display("FAIL st%0d_we_cyc got=%0d exp=3", i, op_we_cyc); end
            n_checks++; if (op_we_d !== t_exp[i]) begin n_fail++; $display("FAIL st%0d_mem_wd got=%h exp=%h", i, op_we_d, t_exp[i]); end
            n_checks++; if (op_done_cyc !== 4) begin n_fail++; $display("FAIL st%0d_done_cyc got=%0d exp=4", i, op_done_cyc); end
            n_checks++; if (op_rdata !== 32'h8899AABB) begin n_fail++; $display("FAIL st%0d_rdata_kept got=%h exp=8899aabb", i, op_rdata); end
        end
        run_op(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 1);
        n_checks++; if (op_rdata !== 32'hC3345ABB) begin n_fail++; $display("FAIL st_readback got=%h exp=c3345abb", op_rdata); end
        run_op(1'b0, 2'b00, 1'b0, 32'h103, 32'h0, 1);
        n_checks++; if (op_rdata !== 32'hFFFFFFC3) begin n_fail++; $display("FAIL st_byte3_load got=%h exp=ffffffc3", op_rdata); end
    endtask

    task automatic test_misaligned();
        logic [1:0]  t_sz [3] = '{2'b01, 2'b10, 2'b11};
        logic [31:0] t_a  [3] = '{32'h103, 32'h102, 32'h100};
        for (int i = 0; i < 3; i++) begin
            run_op(i[0], t_sz[i], 1'b0, t_a[i], 32'hDEADBEEF, 1);
            n_checks++; if (op_done_cyc !== 1) begin n_fail++; $display("FAIL mis%0d_done_cyc got=%0d exp=1", i, op_done_cyc); end
            n_checks++; if (op_err !== 1'b1) begin n_fail++; $display("FAIL mis%0d_err got=%b exp=1", i, op_err); end
            n_checks++; if (op_we_cnt !== 0) begin n_fail++; $display("FAIL mis%0d_we_cnt got=%0d exp=0", i, op_we_cnt); end
            n_checks++; if (op_rdata !== 32'hFFFFFFC3) begin n_fail++; $display("FAIL mis%0d_rdata got=%h exp=ffffffc3", i, op_rdata); end
        end
    endtask

    task automatic test_start_while_busy();
        run_op(1'b1, 2'b10, 1'b0, 32'h108, 32'hCAFEF00D, 3);
        n_checks++; if (op_we_cnt !== 1) begin n_fail++; $display("FAIL busy_we_cnt got=%0d exp=1", op_we_cnt); end
        n_checks++; if (op_done_cyc !== 2) begin n_fail++; $display("FAIL busy_done_cyc got=%0d exp=2", op_done_cyc); end
        n_checks++; if (op_err !== 1'b0) begin n_fail++; $display("FAIL busy_err got=%b exp=0", op_err); end
        n_checks++; if (mem[8'h42] !== 32'hCAFEF00D) begin n_fail++; $display("FAIL busy_mem got=%h exp=cafef00d", mem[8'h42]); end
    endtask

    task automatic test_reset_mid_write();
        int seen_done;
        run_op(1'b1, 2'b10, 1'b0, 32'h104, 32'h11223344, 1);
        @(negedge clk);
        is_store = 1'b1; size = 2'b00; uns = 1'b0; addr = 32'h104; wdata = 32'hEE; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        n_checks++; if (mem_we !== 1'b1) begin n_fail++; $display("FAIL rmw_in_wr got=%b exp=1", mem_we); end
        rst = 1'b1; #1;
        n_checks++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL rmw_we_in_rst got=%b exp=0", mem_we); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL rmw_done_in_rst got=%b exp=0", done); end
        @(posedge clk); #1; rst = 1'b0;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rmw_busy_after got=%b exp=0", busy); end
        seen_done = 0;
        for (int k = 0; k < 4; k++) begin
            if (done === 1'b1) seen_done++;
            @(posedge clk); #1;
        end
        n_checks++; if (seen_done !== 0) begin n_fail++; $display("FAIL rmw_no_done got=%0d exp=0", seen_done); end
        n_checks++; if (mem[8'h41] !== 32'h11223344) begin n_fail++; $display("FAIL rmw_mem got=%h exp=11223344", mem[8'h41]); end
        run_op(1'b0, 2'b10, 1'b0, 32'h104, 32'h0, 1);
        n_checks++; if (op_rdata !== 32'h11223344) begin n_fail++; $display("FAIL rmw_readback got=%h exp=11223344", op_rdata); end
    endtask

    initial begin
        test_reset();
        test_word_store();
        test_loads();
        test_subword_store();
        test_misaligned();
        test_start_while_busy();
        test_reset_mid_write();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
